// File: rtl/neighbor_link_queued.sv
// Edge link between two decoder nodes: growth tracking, neighbor root mirror, queued outgoing events.
// Optional NEIGHBOR_LINK_STATS_EN adds stall_cycles / fifo_high_water observation outputs.
module neighbor_link_queued #(
   parameter int LENGTH              = 2,
   parameter int PER_DIMENSION_WIDTH = 4,
   parameter int N_I                 = 0,
   parameter int N_J                 = 0,
   parameter int N_K                 = 0,
   parameter int FIFO_DEPTH          = 16,
   localparam int AW                 = 3*PER_DIMENSION_WIDTH
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          initialize,
   input  logic [AW-1:0] a_old_root_in,
   input  logic          a_increase,
   input  logic          a_is_odd_cluster,
   output logic          is_fully_grown,
   output logic          is_odd_cluster,
   output logic [AW-1:0] b_old_root_out,
   output logic [AW+1:0] neighbor_fifo_out_data,
   output logic          neighbor_fifo_out_valid,
   input  logic          neighbor_fifo_out_ready,
   input  logic [AW+1:0] neighbor_fifo_in_data,
   input  logic          neighbor_fifo_in_valid,
   output logic          neighbor_fifo_in_ready
`ifdef NEIGHBOR_LINK_STATS_EN
   ,
   output logic [15:0]                    stall_cycles,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_high_water
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(LENGTH+3);
   localparam logic [1:0] MSG_ROOT = 2'b00;
   localparam logic [1:0] MSG_INC  = 2'b01;
   localparam logic [1:0] MSG_ODD  = 2'b10;
   localparam logic [AW-1:0] INIT_ROOT = {PER_DIMENSION_WIDTH'(N_K), PER_DIMENSION_WIDTH'(N_I),
                                          PER_DIMENSION_WIDTH'(N_J)};

   logic [GW-1:0] r_growth, r_pend_inc;
   logic          r_is_odd, r_b_odd, r_odd_prev, r_pend_root, r_pend_odd, r_in_ready;
   logic [AW-1:0] r_b_root, r_shadow;
   logic [PW:0]   r_wr_ptr, r_rd_ptr;
   logic [AW+1:0] r_mem [FIFO_DEPTH];

   logic [1:0]    w_in_type;
   logic          w_b_inc, w_b_root, w_b_odd;
   logic          w_empty, w_full, w_pop, w_pending, w_push;
   logic          w_drain_root, w_drain_inc, w_drain_odd;
   logic          w_cap_root, w_cap_odd;
   logic [GW-1:0] w_grow_sum, w_inc_next;
   logic [1:0]    w_wr_type;

   assign w_in_type = neighbor_fifo_in_data[AW+1:AW];
   assign w_b_inc   = neighbor_fifo_in_valid & (w_in_type == MSG_INC);
   assign w_b_root  = neighbor_fifo_in_valid & (w_in_type == MSG_ROOT);
   assign w_b_odd   = neighbor_fifo_in_valid & (w_in_type == MSG_ODD);

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) & (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign w_pop   = ~w_empty & neighbor_fifo_out_ready;

   // A full FIFO still accepts a write in the cycle it is popped.
   assign w_pending    = r_pend_root | (r_pend_inc != '0) | r_pend_odd;
   assign w_push       = ~initialize & w_pending & (~w_full | w_pop);
   assign w_drain_root = w_push & r_pend_root;
   assign w_drain_inc  = w_push & ~r_pend_root & (r_pend_inc != '0);
   assign w_drain_odd  = w_push & ~r_pend_root & (r_pend_inc == '0) & r_pend_odd;
   assign w_wr_type    = r_pend_root ? MSG_ROOT : ((r_pend_inc != '0) ? MSG_INC : MSG_ODD);

   assign w_cap_root = (a_old_root_in != r_shadow);
   assign w_cap_odd  = a_is_odd_cluster & ~r_odd_prev;

   always_comb begin
      w_grow_sum = r_growth + GW'(a_increase) + GW'(w_b_inc);
      if (w_grow_sum > GW'(LENGTH)) w_grow_sum = GW'(LENGTH);
      w_inc_next = r_pend_inc - GW'(w_drain_inc) + GW'(a_increase);
      if (w_inc_next > GW'(LENGTH)) w_inc_next = GW'(LENGTH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_growth    <= '0;
         r_is_odd    <= 1'b0;
         r_b_root    <= '0;
         r_b_odd     <= 1'b0;
         r_shadow    <= '0;
         r_odd_prev  <= 1'b0;
         r_pend_root <= 1'b0;
         r_pend_inc  <= '0;
         r_pend_odd  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
      end else begin
         r_in_ready <= 1'b1;
         r_odd_prev <= a_is_odd_cluster;
         if (initialize) begin
            r_growth    <= '0;
            r_is_odd    <= 1'b0;
            r_b_root    <= INIT_ROOT;
            r_b_odd     <= 1'b0;
            r_shadow    <= a_old_root_in;
            r_pend_root <= 1'b0;
            r_pend_inc  <= '0;
            r_pend_odd  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
         end else begin
            r_growth <= w_grow_sum;
            r_is_odd <= (r_growth == GW'(LENGTH)) & (a_is_odd_cluster | r_b_odd);
            if (w_b_root) r_b_root <= neighbor_fifo_in_data[AW-1:0];
            if (w_b_odd)  r_b_odd  <= 1'b1;
            if (w_cap_root) r_shadow <= a_old_root_in;
            // Fresh capture overrides a drain of the same flag.
            r_pend_root <= w_cap_root | (r_pend_root & ~w_drain_root);
            r_pend_odd  <= w_cap_odd  | (r_pend_odd  & ~w_drain_odd);
            r_pend_inc  <= w_inc_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= {w_wr_type, r_shadow};
   end

   assign is_fully_grown          = (r_growth == GW'(LENGTH));
   assign is_odd_cluster          = r_is_odd;
   assign b_old_root_out          = r_b_root;
   assign neighbor_fifo_out_data  = r_mem[r_rd_ptr[PW-1:0]];
   assign neighbor_fifo_out_valid = ~w_empty;
   assign neighbor_fifo_in_ready  = r_in_ready;

`ifdef NEIGHBOR_LINK_STATS_EN
   logic [15:0] r_stall;
   logic [PW:0] r_hw;
   logic [PW:0] w_count;

   assign w_count = r_wr_ptr - r_rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall <= '0;
         r_hw    <= '0;
      end else if (initialize) begin
         r_stall <= '0;
         r_hw    <= '0;
      end else begin
         if (w_pending & w_full & (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
         if (w_count > r_hw) r_hw <= w_count;
      end
   end

   assign stall_cycles    = r_stall;
   assign fifo_high_water = r_hw;
`endif

endmodule
